// File: rtl/am_radio_ctrl_n_if.sv
// am_radio_ctrl_n_if: register bus between the bus bridge (master) and the
// AM datapath control block (slave). Single-cycle strobes, registered ack.
interface am_radio_ctrl_n_if;
    logic [31:0] sys_addr;
    logic [31:0] sys_wdata;
    logic        sys_wen;
    logic        sys_ren;
    logic [31:0] sys_rdata;
    logic        sys_ack;
    logic        sys_err;

    modport master (
        output sys_addr,
        output sys_wdata,
        output sys_wen,
        output sys_ren,
        input  sys_rdata,
        input  sys_ack,
        input  sys_err
    );

    modport slave (
        input  sys_addr,
        input  sys_wdata,
        input  sys_wen,
        input  sys_ren,
        output sys_rdata,
        output sys_ack,
        output sys_err
    );
endinterface

// File: rtl/am_radio_ctrl_n.sv
// am_radio_ctrl_n: register block for the multi-channel AM NCO/modulator bank.
// Channel settings are double-buffered (shadow -> active) and only copied on
// an update_tick after a COMMIT, so retunes land on frame boundaries.
// A heartbeat watchdog gates master_enable; unmapped accesses raise sys_err.
//
// Optional build macro: AM_CTRL_READBACK_ACTIVE_EN
//   defined   -> 0x010 reads active CH_ENABLE, 0x200+4i reads active FREQ[i]
//   undefined -> those addresses are unmapped
//
// Commit FSM:
//   state      | meaning
//   ST_IDLE    | no commit requested, active set stable
//   ST_PENDING | commit requested, waiting for the next update_tick
module am_radio_ctrl_n #(
    parameter int          NUM_CH    = 12,
    parameter int          WD_CYCLES = 625_000_000,
    parameter logic [31:0] BASE_INC  = 32'h0108D032,
    parameter logic [31:0] STEP_INC  = 32'h00346DC6
) (
    input  logic                   clk,
    input  logic                   rst,
    am_radio_ctrl_n_if.slave       bus,
    input  logic                   update_tick_i,
    output logic                   master_enable_o,
    output logic                   source_sel_o,
    output logic [3:0]             msg_select_o,
    output logic [NUM_CH-1:0]      ch_enable_o,
    output logic [NUM_CH*32-1:0]   ch_phase_inc_o,
    output logic                   update_pulse_o,
    output logic                   watchdog_triggered_o,
    output logic                   watchdog_warning_o
);

    localparam int          IW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [31:0] WD_LOAD  = 32'(WD_CYCLES);
    localparam logic [31:0] WD_WARN  = 32'(WD_CYCLES / 4);
    localparam logic [6:0]  NUM_CH_W = 7'(NUM_CH);
    localparam logic [7:0]  NUM_CH_B = 8'(NUM_CH);
    localparam logic [31:0] UNMAPPED = 32'hDEADBEEF;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic               commit_fire;

    logic               en_q, src_q, wd_en_q;
    logic [3:0]         msg_q;

    logic [31:0]        sh_freq_q  [NUM_CH];
    logic [31:0]        act_freq_q [NUM_CH];
    logic [NUM_CH-1:0]  sh_en_q, act_en_q;
    logic               update_pulse_q;

    logic [31:0]        wd_cnt_q, wd_cnt_d;
    logic               wd_trig_q, wd_trig_d;
    logic               wd_warn;

    logic               ack_q, ack_d;
    logic               err_q, err_d;
    logic [31:0]        rdata_q, rdata_d;

    logic [11:0]        addr;
    logic               aligned, slot_ok;
    logic [IW-1:0]      fidx;
    logic               hit_ctrl, hit_status, hit_chen, hit_commit, hit_freq;
    logic               hit_rb_en, hit_rb_freq, mapped;
    logic               wr_ctrl, wr_chen, wr_commit, wr_freq;
    logic               heartbeat, wd_clear;
    logic [31:0]        rd_val;
    logic               unused_addr;

    assign unused_addr = ^bus.sys_addr[31:12];

    // Address decode: only [11:0] matter, FREQ slots must be word aligned and < NUM_CH.
    always_comb begin
        addr       = bus.sys_addr[11:0];
        aligned    = (addr[1:0] == 2'b00);
        slot_ok    = ({1'b0, addr[7:2]} < NUM_CH_W);
        fidx       = addr[2 +: IW];
        hit_ctrl   = (addr == 12'h000);
        hit_status = (addr == 12'h004);
        hit_chen   = (addr == 12'h008);
        hit_commit = (addr == 12'h00C);
        hit_freq   = (addr[11:8] == 4'h1) && aligned && slot_ok;
`ifdef AM_CTRL_READBACK_ACTIVE_EN
        hit_rb_en   = (addr == 12'h010);
        hit_rb_freq = (addr[11:8] == 4'h2) && aligned && slot_ok;
`else
        hit_rb_en   = 1'b0;
        hit_rb_freq = 1'b0;
`endif
        mapped    = hit_ctrl | hit_status | hit_chen | hit_commit | hit_freq
                  | hit_rb_en | hit_rb_freq;
        wr_ctrl   = bus.sys_wen && hit_ctrl;
        wr_chen   = bus.sys_wen && hit_chen;
        wr_commit = bus.sys_wen && hit_commit && bus.sys_wdata[0];
        wr_freq   = bus.sys_wen && hit_freq;
        heartbeat = bus.sys_wen && mapped;
        wd_clear  = wr_ctrl && bus.sys_wdata[9];
    end

    // Read mux from current register state, so a colliding write returns old data.
    always_comb begin
        rd_val = UNMAPPED;
        if (hit_ctrl) begin
            rd_val = {22'h0, 1'b0, wd_en_q, msg_q, src_q, 2'b00, en_q};
        end else if (hit_status) begin
            rd_val = {16'h0, NUM_CH_B, 4'h0, (state_q == ST_PENDING),
                      wd_warn, wd_trig_q, master_enable_o};
        end else if (hit_chen) begin
            rd_val = 32'(sh_en_q);
        end else if (hit_commit) begin
            rd_val = 32'h0;
        end else if (hit_freq) begin
            rd_val = sh_freq_q[fidx];
        end else if (hit_rb_en) begin
            rd_val = 32'(act_en_q);
        end else if (hit_rb_freq) begin
            rd_val = act_freq_q[fidx];
        end
    end

    // Bus response next-state: ack one cycle after any strobe, err for unmapped.
    always_comb begin
        ack_d   = bus.sys_wen | bus.sys_ren;
        err_d   = (bus.sys_wen | bus.sys_ren) & ~mapped;
        rdata_d = bus.sys_ren ? rd_val : 32'h0;
    end

    // Bus response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'h0;
        end else begin
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // CTRL register; wd_clear is a write-only pulse and is never stored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q    <= 1'b0;
            src_q   <= 1'b0;
            msg_q   <= 4'h0;
            wd_en_q <= 1'b1;
        end else if (wr_ctrl) begin
            en_q    <= bus.sys_wdata[0];
            src_q   <= bus.sys_wdata[3];
            msg_q   <= bus.sys_wdata[7:4];
            wd_en_q <= bus.sys_wdata[8];
        end
    end

    // Shadow channel registers, written directly by the bus.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_en_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                sh_freq_q[i] <= BASE_INC + STEP_INC * 32'(i);
            end
        end else begin
            if (wr_chen) begin
                sh_en_q <= bus.sys_wdata[NUM_CH-1:0];
            end
            if (wr_freq) begin
                sh_freq_q[fidx] <= bus.sys_wdata;
            end
        end
    end

    // Commit FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Commit FSM next state; a tick in the COMMIT-write cycle is not seen
    // because the FSM is still IDLE then.
    always_comb begin
        state_d     = state_q;
        commit_fire = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (wr_commit) begin
                    state_d = ST_PENDING;
                end
            end
            ST_PENDING: begin
                if (update_tick_i) begin
                    commit_fire = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Active set copy; takes the pre-edge shadow, so a colliding bus write waits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_en_q       <= '0;
            update_pulse_q <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                act_freq_q[i] <= BASE_INC + STEP_INC * 32'(i);
            end
        end else begin
            update_pulse_q <= commit_fire;
            if (commit_fire) begin
                act_en_q <= sh_en_q;
                for (int i = 0; i < NUM_CH; i++) begin
                    act_freq_q[i] <= sh_freq_q[i];
                end
            end
        end
    end

    // Watchdog next state: reload on heartbeat/disable/clear, else saturating countdown.
    always_comb begin
        wd_cnt_d  = wd_cnt_q;
        wd_trig_d = wd_trig_q;
        if (!wd_en_q || heartbeat || wd_clear) begin
            wd_cnt_d = WD_LOAD;
        end else if (wd_cnt_q != 32'h0) begin
            wd_cnt_d = wd_cnt_q - 32'h1;
        end
        if (wd_clear) begin
            wd_trig_d = 1'b0;
        end else if (wd_en_q && (wd_cnt_q == 32'h0)) begin
            wd_trig_d = 1'b1;
        end
    end

    // Watchdog registers; the trigger is sticky until wd_clear or reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt_q  <= WD_LOAD;
            wd_trig_q <= 1'b0;
        end else begin
            wd_cnt_q  <= wd_cnt_d;
            wd_trig_q <= wd_trig_d;
        end
    end

    assign wd_warn = wd_en_q && (wd_cnt_q < WD_WARN);

    // Flatten the active increments for the NCO bank.
    always_comb begin
        ch_phase_inc_o = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            ch_phase_inc_o[32*i +: 32] = act_freq_q[i];
        end
    end

    assign bus.sys_ack           = ack_q;
    assign bus.sys_err           = err_q;
    assign bus.sys_rdata         = rdata_q;
    assign master_enable_o       = en_q & ~wd_trig_q;
    assign source_sel_o          = src_q;
    assign msg_select_o          = msg_q;
    assign ch_enable_o           = act_en_q;
    assign update_pulse_o        = update_pulse_q;
    assign watchdog_triggered_o  = wd_trig_q;
    assign watchdog_warning_o    = wd_warn;

endmodule

// File: tb/tb_am_radio_ctrl_n.sv
// Directed bench for am_radio_ctrl_n with NUM_CH=12, WD_CYCLES=100.
// Bus responses are checked by a scoreboard queue popped on sys_ack.
module tb_am_radio_ctrl_n;
    localparam int NUM_CH = 12;
    localparam int WD     = 100;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  tick;
    logic                  master_enable, source_sel, update_pulse, wd_trig, wd_warn;
    logic [3:0]            msg_select;
    logic [NUM_CH-1:0]     ch_enable;
    logic [NUM_CH*32-1:0]  ch_inc;

    always #5 clk = ~clk;

    am_radio_ctrl_n_if bus();

    am_radio_ctrl_n #(
        .NUM_CH    (NUM_CH),
        .WD_CYCLES (WD),
        .BASE_INC  (32'h0108D032),
        .STEP_INC  (32'h00346DC6)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .bus                  (bus),
        .update_tick_i        (tick),
        .master_enable_o      (master_enable),
        .source_sel_o         (source_sel),
        .msg_select_o         (msg_select),
        .ch_enable_o          (ch_enable),
        .ch_phase_inc_o       (ch_inc),
        .update_pulse_o       (update_pulse),
        .watchdog_triggered_o (wd_trig),
        .watchdog_warning_o   (wd_warn)
    );

    typedef struct {
        string       name;
        logic        chk_data;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] inc(input int i);
        return ch_inc[32*i +: 32];
    endfunction

    task automatic bus_wr(input string name, input logic [31:0] a, input logic [31:0] d,
                          input logic exp_err);
        exp_t e;
        @(negedge clk);
        bus.sys_addr  = a;
        bus.sys_wdata = d;
        bus.sys_wen   = 1'b1;
        e.name = name; e.chk_data = 1'b0; e.data = 32'h0; e.err = exp_err;
        q.push_back(e);
        @(negedge clk);
        bus.sys_wen = 1'b0;
    endtask

    task automatic bus_rd(input string name, input logic [31:0] a, input logic [31:0] exp_d,
                          input logic exp_err);
        exp_t e;
        @(negedge clk);
        bus.sys_addr = a;
        bus.sys_ren  = 1'b1;
        e.name = name; e.chk_data = 1'b1; e.data = exp_d; e.err = exp_err;
        q.push_back(e);
        @(negedge clk);
        bus.sys_ren = 1'b0;
    endtask

    task automatic pulse_tick();
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    // Monitor: every ack pops one expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.sys_ack) begin
                n_checks++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_ack: got ack with rdata %08h, required no ack",
                             bus.sys_rdata);
                end else begin
                    e = q.pop_front();
                    if ((e.chk_data && (bus.sys_rdata !== e.data)) || (bus.sys_err !== e.err)) begin
                        n_fail++;
                        $display("FAIL %s: got rdata %08h err %0b, expected rdata %08h err %0b (data checked %0b)",
                                 e.name, bus.sys_rdata, bus.sys_err, e.data, e.err, e.chk_data);
                    end
                end
            end
        end
    end

    initial begin
        int warn_c;
        int trig_c;
        exp_t e;
        rst           = 1'b1;
        tick          = 1'b0;
        bus.sys_addr  = 32'h0;
        bus.sys_wdata = 32'h0;
        bus.sys_wen   = 1'b0;
        bus.sys_ren   = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        chk("rst_ch_enable", 32'(ch_enable), 32'h0);
        chk("rst_master_enable", 32'(master_enable), 32'h0);
        chk("rst_update_pulse", 32'(update_pulse), 32'h0);
        chk("rst_wd_trig", 32'(wd_trig), 32'h0);
        chk("rst_inc0", inc(0), 32'h0108D032);
        chk("rst_inc1", inc(1), 32'h013D3DF8);
        chk("rst_inc11", inc(11), 32'h034987B4);
        bus_rd("rd_freq0_rst", 32'h100, 32'h0108D032, 1'b0);
        bus_rd("rd_freq11_rst", 32'h12C, 32'h034987B4, 1'b0);
        bus_rd("rd_ctrl_rst", 32'h000, 32'h00000100, 1'b0);
        bus_rd("rd_status_rst", 32'h004, 32'h00000C00, 1'b0);

        // Park the watchdog while exercising the channel path
        bus_wr("wr_ctrl_0", 32'h000, 32'h0, 1'b0);

        // Shadow writes must not reach the active set
        bus_wr("wr_freq1", 32'h104, 32'h02000000, 1'b0);
        bus_wr("wr_chen", 32'h008, 32'h00000FFF, 1'b0);
        chk("shadow_inc1_held", inc(1), 32'h013D3DF8);
        chk("shadow_chen_held", 32'(ch_enable), 32'h0);
        bus_rd("rd_freq1_shadow", 32'h104, 32'h02000000, 1'b0);
        bus_rd("rd_chen_shadow", 32'h008, 32'h00000FFF, 1'b0);
        pulse_tick();
        chk("idle_tick_no_commit", 32'(ch_enable), 32'h0);

        // Commit and apply
        bus_wr("wr_commit", 32'h00C, 32'h1, 1'b0);
        bus_rd("rd_status_pending", 32'h004, 32'h00000C08, 1'b0);
        chk("pending_pulse_low", 32'(update_pulse), 32'h0);
        pulse_tick();
        chk("commit_inc1", inc(1), 32'h02000000);
        chk("commit_chen", 32'(ch_enable), 32'h00000FFF);
        chk("commit_pulse_high", 32'(update_pulse), 32'h1);
        @(negedge clk);
        chk("commit_pulse_low", 32'(update_pulse), 32'h0);
        bus_rd("rd_status_done", 32'h004, 32'h00000C00, 1'b0);

`ifdef AM_CTRL_READBACK_ACTIVE_EN
        bus_rd("rd_active_freq1", 32'h204, 32'h02000000, 1'b0);
        bus_rd("rd_active_chen", 32'h010, 32'h00000FFF, 1'b0);
`else
        bus_rd("rd_active_freq1", 32'h204, 32'hDEADBEEF, 1'b1);
        bus_rd("rd_active_chen", 32'h010, 32'hDEADBEEF, 1'b1);
`endif

        // Unmapped accesses
        bus_rd("rd_unmapped_ch12", 32'h130, 32'hDEADBEEF, 1'b1);
        bus_wr("wr_unmapped_0f0", 32'h0F0, 32'hFFFFFFFF, 1'b1);
        bus_wr("wr_unmapped_ch12", 32'h130, 32'h12345678, 1'b1);
        bus_rd("rd_ctrl_after_unmapped", 32'h000, 32'h0, 1'b0);
        bus_rd("rd_chen_after_unmapped", 32'h008, 32'h00000FFF, 1'b0);
        bus_rd("rd_commit_zero", 32'h00C, 32'h0, 1'b0);

        // CTRL fields
        bus_wr("wr_ctrl_f9", 32'h000, 32'h000000F9, 1'b0);
        chk("ctrl_master_enable", 32'(master_enable), 32'h1);
        chk("ctrl_source_sel", 32'(source_sel), 32'h1);
        chk("ctrl_msg_select", 32'(msg_select), 32'hF);
        bus_rd("rd_ctrl_f9", 32'h000, 32'h000000F9, 1'b0);

        // Shadow write colliding with the consuming tick
        bus_wr("wr_chen_00f", 32'h008, 32'h0000000F, 1'b0);
        bus_wr("wr_commit2", 32'h00C, 32'h1, 1'b0);
        @(negedge clk);
        bus.sys_addr  = 32'h108;
        bus.sys_wdata = 32'h11111111;
        bus.sys_wen   = 1'b1;
        tick          = 1'b1;
        e.name = "wr_freq2_collide"; e.chk_data = 1'b0; e.data = 32'h0; e.err = 1'b0;
        q.push_back(e);
        @(negedge clk);
        bus.sys_wen = 1'b0;
        tick        = 1'b0;
        chk("collide_chen_applied", 32'(ch_enable), 32'h0000000F);
        chk("collide_inc2_old", inc(2), 32'h0171ABBE);
        bus_rd("rd_freq2_shadow_new", 32'h108, 32'h11111111, 1'b0);
        bus_wr("wr_commit3", 32'h00C, 32'h1, 1'b0);
        pulse_tick();
        chk("recommit_inc2_new", inc(2), 32'h11111111);

        // Simultaneous write and read: read returns pre-write data
        @(negedge clk);
        bus.sys_addr  = 32'h10C;
        bus.sys_wdata = 32'hABCD0000;
        bus.sys_wen   = 1'b1;
        bus.sys_ren   = 1'b1;
        e.name = "rdwr_freq3_old"; e.chk_data = 1'b1; e.data = 32'h01A61984; e.err = 1'b0;
        q.push_back(e);
        @(negedge clk);
        bus.sys_wen = 1'b0;
        bus.sys_ren = 1'b0;
        bus_rd("rd_freq3_new", 32'h10C, 32'hABCD0000, 1'b0);

        // Watchdog: arm, then let it expire
        bus_wr("wr_ctrl_101", 32'h000, 32'h00000101, 1'b0);
        warn_c = -1;
        trig_c = -1;
        for (int c = 1; c <= 150; c++) begin
            @(negedge clk);
            if (warn_c < 0 && wd_warn) warn_c = c;
            if (trig_c < 0 && wd_trig) trig_c = c;
        end
        chk("wd_warn_cycle", 32'(warn_c), 32'd76);
        chk("wd_trig_cycle", 32'(trig_c), 32'd101);
        chk("wd_master_off", 32'(master_enable), 32'h0);
        bus_wr("wr_heartbeat", 32'h008, 32'h00000FFF, 1'b0);
        chk("wd_trig_sticky", 32'(wd_trig), 32'h1);
        bus_rd("rd_status_trig", 32'h004, 32'h00000C02, 1'b0);
        bus_wr("wr_ctrl_301", 32'h000, 32'h00000301, 1'b0);
        chk("wd_clear_trig", 32'(wd_trig), 32'h0);
        chk("wd_clear_master_on", 32'(master_enable), 32'h1);
        bus_rd("rd_ctrl_clear_reads0", 32'h000, 32'h00000101, 1'b0);

        // Reset while a commit is pending
        bus_wr("wr_commit_pre_rst", 32'h00C, 32'h1, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rstmid_inc1_default", inc(1), 32'h013D3DF8);
        chk("rstmid_chen", 32'(ch_enable), 32'h0);
        bus_rd("rd_status_rstmid", 32'h004, 32'h00000C00, 1'b0);
        pulse_tick();
        chk("rstmid_commit_lost", 32'(update_pulse), 32'h0);

        // Drain the scoreboard
        for (int k = 0; k < 10 && q.size() != 0; k++) @(negedge clk);
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d responses missing, required 0", q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
